// File: rtl/aq_gemac_tx_arb_pkg.sv
// aq_gemac_tx_arb_pkg: arbiter state encodings shared by the TX/RX write-port arbiters,
// plus the frame-admission space check.
package aq_gemac_tx_arb_pkg;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_CHECK = 2'd1,
    A_DATA  = 2'd2,
    A_DRAIN = 2'd3
  } arbState_t;

  localparam int unsigned WORDS_W = 10;

  // One extra bit so words + margin can never wrap past the free-space count.
  function automatic logic spaceOk(input logic [WORDS_W-1:0] space,
                                   input logic [WORDS_W-1:0] words,
                                   input int unsigned        margin);
    logic [WORDS_W:0] need;
    need = {1'b0, words} + (WORDS_W+1)'(margin);
    return ({1'b0, space} >= need);
  endfunction

endpackage

// File: rtl/aq_gemac_rr_arb2.sv
// aq_gemac_rr_arb2: 2-way pick from a VALID pair against the last winner.
// Define AQ_GEMAC_TX_ARB_PRIO_EN for strict REQ0 priority (pointer ignored).
module aq_gemac_rr_arb2
  import aq_gemac_tx_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic lastWin,
  output logic anyValid,
  output logic pick
);

  assign anyValid = valid0 | valid1;

`ifdef AQ_GEMAC_TX_ARB_PRIO_EN
  logic unusedLastWin;
  assign unusedLastWin = lastWin;

  always_comb begin
    pick = !valid0;
  end
`else
  always_comb begin
    if (valid0 && valid1) pick = !lastWin;
    else                  pick = valid1;
  end
`endif

endmodule

// File: rtl/aq_gemac_tx_arb.sv
// aq_gemac_tx_arb: admits whole frames from two sources onto the TX-buffer write port,
// with watchdog termination. AQ_GEMAC_TX_ARB_PRIO_EN selects strict REQ0 priority.
module aq_gemac_tx_arb
  import aq_gemac_tx_arb_pkg::*;
#(
  parameter int unsigned SPACE_MARGIN = 2,
  parameter int unsigned TIMEOUT_CYC  = 4096,
  parameter int unsigned TO_W         = 12
)(
  input  logic        BUFF_CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  input  logic [9:0]  REQ0_WORDS,
  input  logic        REQ0_WE,
  input  logic        REQ0_END,
  input  logic [31:0] REQ0_DATA,
  input  logic        REQ1_VALID,
  input  logic [9:0]  REQ1_WORDS,
  input  logic        REQ1_WE,
  input  logic        REQ1_END,
  input  logic [31:0] REQ1_DATA,
  output logic        GNT0,
  output logic        GNT1,
  output logic        ACK0,
  output logic        ACK1,
  input  logic        BUFF_READY,
  input  logic        BUFF_FULL,
  input  logic [9:0]  BUFF_SPACE,
  output logic        BUFF_WE,
  output logic        BUFF_START,
  output logic        BUFF_END,
  output logic [31:0] BUFF_DATA,
  output logic        ARB_ERR
);

  arbState_t        state, nextState;
  logic             win, lastWin, started, toPend, sawLow, drainWait;
  logic [TO_W-1:0]  wdog;
  logic             anyValid, pick, selOk;
  logic [9:0]       selWords;
  logic             selWe, selEnd;
  logic [31:0]      selData;

  aq_gemac_rr_arb2 uPick (
    .valid0   (REQ0_VALID),
    .valid1   (REQ1_VALID),
    .lastWin  (lastWin),
    .anyValid (anyValid),
    .pick     (pick)
  );

  // Candidate in A_CHECK is the live pick; the data path follows the latched winner.
  always_comb begin
    selWords = pick ? REQ1_WORDS : REQ0_WORDS;
    selOk    = BUFF_READY && spaceOk(BUFF_SPACE, selWords, SPACE_MARGIN);
    selWe    = win ? REQ1_WE   : REQ0_WE;
    selEnd   = win ? REQ1_END  : REQ0_END;
    selData  = win ? REQ1_DATA : REQ0_DATA;
  end

  always_ff @(posedge BUFF_CLK) begin
    if (RST) state <= A_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      A_IDLE:  if (anyValid) nextState = A_CHECK;
      A_CHECK: begin
        if (!anyValid)  nextState = A_IDLE;
        else if (selOk) nextState = A_DATA;
      end
      A_DATA:  if (BUFF_END) nextState = A_DRAIN;
      A_DRAIN: if (BUFF_READY && (sawLow || drainWait)) nextState = A_IDLE;
      default: nextState = A_IDLE;
    endcase
  end

  always_comb begin
    GNT0       = 1'b0;
    GNT1       = 1'b0;
    ACK0       = 1'b0;
    ACK1       = 1'b0;
    BUFF_WE    = 1'b0;
    BUFF_START = 1'b0;
    BUFF_END   = 1'b0;
    BUFF_DATA  = '0;
    ARB_ERR    = 1'b0;
    if (state == A_DATA) begin
      GNT0 = !win;
      GNT1 = win;
      if (toPend) begin
        // Forced terminator: zero word closing the frame; source word is not accepted.
        BUFF_WE    = !BUFF_FULL;
        BUFF_END   = !BUFF_FULL;
        BUFF_START = !BUFF_FULL && !started;
        ARB_ERR    = !BUFF_FULL;
      end else begin
        BUFF_WE    = selWe && !BUFF_FULL;
        BUFF_END   = selEnd && BUFF_WE;
        BUFF_START = BUFF_WE && !started;
        BUFF_DATA  = selData;
        ACK0       = BUFF_WE && !win;
        ACK1       = BUFF_WE && win;
      end
    end
  end

  always_ff @(posedge BUFF_CLK) begin
    if (RST) begin
      win       <= 1'b0;
      lastWin   <= 1'b1;
      started   <= 1'b0;
      toPend    <= 1'b0;
      wdog      <= '0;
      sawLow    <= 1'b0;
      drainWait <= 1'b0;
    end else begin
      case (state)
        A_CHECK: begin
          win       <= pick;
          started   <= 1'b0;
          toPend    <= 1'b0;
          wdog      <= '0;
          sawLow    <= 1'b0;
          drainWait <= 1'b0;
        end
        A_DATA: begin
          if (BUFF_WE)  started <= 1'b1;
          if (BUFF_END) lastWin <= win;
          if (ACK0 || ACK1) begin
            wdog <= '0;
          end else if (!BUFF_FULL && !toPend) begin
            // Terminator is staged one cycle later so the count fits in TO_W bits.
            if (wdog == TO_W'(TIMEOUT_CYC - 1)) toPend <= 1'b1;
            else                                 wdog   <= wdog + TO_W'(1);
          end
        end
        A_DRAIN: begin
          if (!BUFF_READY) sawLow <= 1'b1;
          drainWait <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
